// File: rtl/bus_fifo_port.sv
// Memory-bus responder with a four-word register window in front of a TX FIFO
// and an RX FIFO. The A and S registers carry the address and data phases of a bus cycle.
module bus_fifo_port #(
  parameter int                       WORD_WIDTH    = 16,
  parameter int                       ADDRESS_WIDTH = 12,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = 12'hFF0,
  parameter int                       DEPTH         = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  inout  logic [ADDRESS_WIDTH-1:0] Abus,
  inout  logic [WORD_WIDTH-1:0]    Dbus,
  input  logic                     Ain,
  input  logic                     Din,
  input  logic                     Dout,
  input  logic                     read,
  input  logic                     write,
  output logic [WORD_WIDTH-1:0]    tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  input  logic [WORD_WIDTH-1:0]    rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [ADDRESS_WIDTH-1:0] a_reg;
  logic [WORD_WIDTH-1:0]    s_reg, s_next;
  logic [WORD_WIDTH-1:0]    tx_mem [DEPTH];
  logic [WORD_WIDTH-1:0]    rx_mem [DEPTH];
  logic [PW-1:0]            tx_wr_ptr_reg, tx_rd_ptr_reg, rx_wr_ptr_reg, rx_rd_ptr_reg;
  logic [CW-1:0]            tx_count_reg, rx_count_reg;
  logic                     rx_ovf_reg, tx_drop_reg;

  logic                     sel;
  logic [1:0]               off;
  logic                     cpu_rd, cpu_wr, flush;
  logic                     tx_full, tx_push, tx_pop, tx_drop;
  logic                     rx_push, rx_pop, rx_ovf;
  logic [WORD_WIDTH-1:0]    status;

  assign sel = (a_reg[ADDRESS_WIDTH-1:2] == BASE_ADDR[ADDRESS_WIDTH-1:2]);
  assign off = a_reg[1:0];

  // Abus is only ever sampled; Dbus is released unless a selected read-out is requested.
  assign Dbus = (Dout && sel) ? s_reg : {WORD_WIDTH{1'bz}};

  assign cpu_rd = read && sel && !write;
  assign cpu_wr = write && sel;
  assign flush  = cpu_wr && (off == 2'd2);

  // All full/empty decisions below come from the pre-edge counts.
  assign tx_full  = (tx_count_reg == FULL_COUNT);
  assign tx_valid = (tx_count_reg != '0);
  assign tx_data  = tx_mem[tx_rd_ptr_reg];
  assign rx_ready = (rx_count_reg != FULL_COUNT);

  assign tx_push = cpu_wr && (off == 2'd0) && !tx_full;
  assign tx_drop = cpu_wr && (off == 2'd0) && tx_full;
  assign tx_pop  = tx_valid && tx_ready;
  assign rx_push = rx_valid && rx_ready;
  assign rx_ovf  = rx_valid && !rx_ready;
  assign rx_pop  = cpu_rd && (off == 2'd0) && (rx_count_reg != '0);

  always_comb begin
    status    = '0;
    status[0] = (rx_count_reg != '0);
    status[1] = tx_full;
    status[2] = rx_ovf_reg;
    status[3] = tx_drop_reg;
  end

  always_comb begin
    s_next = s_reg;
    if (write) begin
      s_next = s_reg;
    end else if (read && sel) begin
      case (off)
        2'd0:    s_next = (rx_count_reg != '0) ? rx_mem[rx_rd_ptr_reg] : '0;
        2'd1:    s_next = status;
        2'd2:    s_next = WORD_WIDTH'(rx_count_reg);
        default: s_next = '0;
      endcase
    end else if (Din) begin
      s_next = Dbus;
    end
  end

  // Storage arrays carry no reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge CLK) begin
    if (tx_push && !RST) tx_mem[tx_wr_ptr_reg] <= s_reg;
    if (rx_push && !flush && !RST) rx_mem[rx_wr_ptr_reg] <= rx_data;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_reg         <= '0;
      s_reg         <= '0;
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
      tx_count_reg  <= '0;
      rx_count_reg  <= '0;
      rx_ovf_reg    <= 1'b0;
      tx_drop_reg   <= 1'b0;
    end else begin
      if (Ain) a_reg <= Abus;
      s_reg <= s_next;
      if (flush) begin
        tx_wr_ptr_reg <= '0;
        tx_rd_ptr_reg <= '0;
        rx_wr_ptr_reg <= '0;
        rx_rd_ptr_reg <= '0;
        tx_count_reg  <= '0;
        rx_count_reg  <= '0;
        rx_ovf_reg    <= 1'b0;
        tx_drop_reg   <= 1'b0;
      end else begin
        if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + PW'(1);
        if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + PW'(1);
        if (tx_push && !tx_pop)      tx_count_reg <= tx_count_reg + CW'(1);
        else if (!tx_push && tx_pop) tx_count_reg <= tx_count_reg - CW'(1);

        if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + PW'(1);
        if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + PW'(1);
        if (rx_push && !rx_pop)      rx_count_reg <= rx_count_reg + CW'(1);
        else if (!rx_push && rx_pop) rx_count_reg <= rx_count_reg - CW'(1);

        if (tx_drop) tx_drop_reg <= 1'b1;
        if (rx_ovf)  rx_ovf_reg  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_fifo_port.sv
// Directed vector bench for bus_fifo_port: one clock edge per table row, plus a
// hand-written asynchronous reset sequence.
module tb_bus_fifo_port;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [11:0] abus_val = '0;
  logic        drv = 1'b0;
  logic [15:0] dval = '0;
  logic        Ain = 1'b0, Din = 1'b0, Dout = 1'b0, read = 1'b0, write = 1'b0;
  logic        tx_ready = 1'b0, rx_valid = 1'b0;
  logic [15:0] rx_data = '0;
  logic [15:0] tx_data;
  logic        tx_valid, rx_ready;
  wire  [11:0] Abus;
  wire  [15:0] Dbus;

  assign Abus = abus_val;
  assign Dbus = drv ? dval : 16'hzzzz;

  always #5 CLK = ~CLK;

  bus_fifo_port dut (
    .CLK(CLK), .RST(RST), .Abus(Abus), .Dbus(Dbus),
    .Ain(Ain), .Din(Din), .Dout(Dout), .read(read), .write(write),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  localparam int F_AIN = 1, F_DIN = 2, F_DRV = 4, F_DOUT = 8, F_RD = 16,
                 F_WR = 32, F_TXR = 64, F_RXV = 128, F_CHK = 256;

  typedef struct {
    string       name;
    int          flags;
    logic [11:0] abus;
    logic [15:0] dval;
    logic [15:0] rxd;
    logic        etxv;
    logic [15:0] etxd;
    logic        erxr;
    logic [15:0] ed;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input int flags, input logic [11:0] ab,
                     input logic [15:0] dv, input logic [15:0] rxd, input logic etxv,
                     input logic [15:0] etxd, input logic erxr, input logic [15:0] ed);
    vec_t v;
    v.name = nm; v.flags = flags; v.abus = ab; v.dval = dv; v.rxd = rxd;
    v.etxv = etxv; v.etxd = etxd; v.erxr = erxr; v.ed = ed;
    vecs.push_back(v);
  endtask

  task automatic run_vecs();
    foreach (vecs[i]) begin
      Ain      = (vecs[i].flags & F_AIN) != 0;
      Din      = (vecs[i].flags & F_DIN) != 0;
      drv      = (vecs[i].flags & F_DRV) != 0;
      Dout     = (vecs[i].flags & F_DOUT) != 0;
      read     = (vecs[i].flags & F_RD) != 0;
      write    = (vecs[i].flags & F_WR) != 0;
      tx_ready = (vecs[i].flags & F_TXR) != 0;
      rx_valid = (vecs[i].flags & F_RXV) != 0;
      abus_val = vecs[i].abus;
      dval     = vecs[i].dval;
      rx_data  = vecs[i].rxd;
      @(posedge CLK);
      #1;
      chk({vecs[i].name, ".tx_valid"}, 16'(tx_valid), 16'(vecs[i].etxv));
      if (vecs[i].etxv) chk({vecs[i].name, ".tx_data"}, tx_data, vecs[i].etxd);
      chk({vecs[i].name, ".rx_ready"}, 16'(rx_ready), 16'(vecs[i].erxr));
      if ((vecs[i].flags & F_CHK) != 0) chk({vecs[i].name, ".Dbus"}, Dbus, vecs[i].ed);
      $display("vec %-16s tx_valid=%0b tx_data=%h rx_ready=%0b Dbus=%h",
               vecs[i].name, tx_valid, tx_data, rx_ready, Dbus);
    end
    vecs.delete();
    {Ain, Din, drv, Dout, read, write, tx_ready, rx_valid} = '0;
  endtask

  initial begin
    #1;
    chk("reset.tx_valid", 16'(tx_valid), 16'd0);
    chk("reset.rx_ready", 16'(rx_ready), 16'd1);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // Basic write to TX and pop
    add("ain_ff0",    F_AIN, 12'hFF0, 0, 0, 0, 0, 1, 0);
    add("din_1234",   F_DIN | F_DRV, 0, 16'h1234, 0, 0, 0, 1, 0);
    add("wr_1234",    F_WR, 0, 0, 0, 1, 16'h1234, 1, 0);
    add("pop_1234",   F_TXR, 0, 0, 0, 0, 0, 1, 0);
    // Five writes into a four-deep TX with the consumer stalled
    for (int i = 1; i <= 5; i++) begin
      add($sformatf("din_a00%0d", i), F_DIN | F_DRV, 0, 16'hA000 + 16'(i), 0, i > 1, 16'hA001, 1, 0);
      add($sformatf("wr_a00%0d", i), F_WR, 0, 0, 0, 1, 16'hA001, 1, 0);
    end
    add("ain_ff1",    F_AIN, 12'hFF1, 0, 0, 1, 16'hA001, 1, 0);
    add("rd_status",  F_RD | F_DOUT | F_CHK, 0, 0, 0, 1, 16'hA001, 1, 16'h000A);
    add("pop1",       F_TXR, 0, 0, 0, 1, 16'hA002, 1, 0);
    add("pop2",       F_TXR, 0, 0, 0, 1, 16'hA003, 1, 0);
    add("pop3",       F_TXR, 0, 0, 0, 1, 16'hA004, 1, 0);
    add("pop4",       F_TXR, 0, 0, 0, 0, 0, 1, 0);
    add("rd_status2", F_RD | F_DOUT | F_CHK, 0, 0, 0, 0, 0, 1, 16'h0008);
    // RX single word, count, empty read
    add("rx_beef",    F_RXV, 0, 0, 16'hBEEF, 0, 0, 1, 0);
    add("ain_ff0b",   F_AIN, 12'hFF0, 0, 0, 0, 0, 1, 0);
    add("rd_beef",    F_RD | F_DOUT | F_CHK, 0, 0, 0, 0, 0, 1, 16'hBEEF);
    add("ain_ff2",    F_AIN, 12'hFF2, 0, 0, 0, 0, 1, 0);
    add("rd_cnt0",    F_RD | F_DOUT | F_CHK, 0, 0, 0, 0, 0, 1, 16'h0000);
    add("ain_ff0c",   F_AIN, 12'hFF0, 0, 0, 0, 0, 1, 0);
    add("rd_empty",   F_RD | F_DOUT | F_CHK, 0, 0, 0, 0, 0, 1, 16'h0000);
    // Unselected address: bus released, S and RX untouched
    add("din_c0de",   F_DIN | F_DRV, 0, 16'hC0DE, 0, 0, 0, 1, 0);
    add("rx_1111",    F_RXV, 0, 0, 16'h1111, 0, 0, 1, 0);
    add("ain_100",    F_AIN, 12'h100, 0, 0, 0, 0, 1, 0);
    add("rd_unsel",   F_RD | F_DOUT | F_DRV | F_CHK, 0, 16'h5A5A, 0, 0, 0, 1, 16'h5A5A);
    add("ain_ff0_s",  F_AIN | F_DOUT | F_CHK, 12'hFF0, 0, 0, 0, 0, 1, 16'hC0DE);
    add("rd_1111",    F_RD | F_DOUT | F_CHK, 0, 0, 0, 0, 0, 1, 16'h1111);
    // Write beats read: S held and pushed to TX
    add("rdwr",       F_RD | F_WR | F_DOUT | F_CHK, 0, 0, 0, 1, 16'h1111, 1, 16'h1111);
    add("pop_1111",   F_TXR, 0, 0, 0, 0, 0, 1, 0);
    // Fill RX (pointers wrap), then overflow during a CPU pop
    add("rx_fill1",   F_RXV, 0, 0, 16'h0001, 0, 0, 1, 0);
    add("rx_fill2",   F_RXV, 0, 0, 16'h0002, 0, 0, 1, 0);
    add("rx_fill3",   F_RXV, 0, 0, 16'h0003, 0, 0, 1, 0);
    add("rx_fill4",   F_RXV, 0, 0, 16'h0004, 0, 0, 0, 0);
    add("rx_ovf_rd",  F_RXV | F_RD | F_DOUT | F_CHK, 0, 0, 16'h0005, 0, 0, 1, 16'h0001);
    add("ain_ff2b",   F_AIN, 12'hFF2, 0, 0, 0, 0, 1, 0);
    add("rd_cnt3",    F_RD | F_DOUT | F_CHK, 0, 0, 0, 0, 0, 1, 16'h0003);
    add("ain_ff1c",   F_AIN, 12'hFF1, 0, 0, 0, 0, 1, 0);
    add("rd_status3", F_RD | F_DOUT | F_CHK, 0, 0, 0, 0, 0, 1, 16'h000D);
    // TX simultaneous push and pop, then flush overriding an RX push
    add("ain_ff0d",   F_AIN, 12'hFF0, 0, 0, 0, 0, 1, 0);
    add("wr_000d",    F_WR, 0, 0, 0, 1, 16'h000D, 1, 0);
    add("din_7777",   F_DIN | F_DRV, 0, 16'h7777, 0, 1, 16'h000D, 1, 0);
    add("wr_pop",     F_WR | F_TXR, 0, 0, 0, 1, 16'h7777, 1, 0);
    add("ain_ff2c",   F_AIN, 12'hFF2, 0, 0, 1, 16'h7777, 1, 0);
    add("flush",      F_WR | F_RXV, 0, 0, 16'h9999, 0, 0, 1, 0);
    add("rd_cnt_fl",  F_RD | F_DOUT | F_CHK, 0, 0, 0, 0, 0, 1, 16'h0000);
    add("ain_ff1d",   F_AIN, 12'hFF1, 0, 0, 0, 0, 1, 0);
    add("rd_stat_fl", F_RD | F_DOUT | F_CHK, 0, 0, 0, 0, 0, 1, 16'h0000);
    // Load state ahead of an asynchronous reset
    add("p_din_4242", F_DIN | F_DRV, 0, 16'h4242, 0, 0, 0, 1, 0);
    add("p_ain_ff0",  F_AIN, 12'hFF0, 0, 0, 0, 0, 1, 0);
    add("p_wr",       F_WR, 0, 0, 0, 1, 16'h4242, 1, 0);
    add("p_rx",       F_RXV, 0, 0, 16'h8888, 1, 16'h4242, 1, 0);
    run_vecs();

    // Reset asserted between edges must act immediately
    rx_valid = 1'b1;
    rx_data  = 16'h6666;
    #3;
    RST = 1'b1;
    #1;
    chk("arst.tx_valid", 16'(tx_valid), 16'd0);
    chk("arst.rx_ready", 16'(rx_ready), 16'd1);
    Dout = 1'b1;
    drv  = 1'b1;
    dval = 16'h5A5A;
    #1;
    chk("arst.Dbus_released", Dbus, 16'h5A5A);
    $display("vec %-16s tx_valid=%0b rx_ready=%0b Dbus=%h", "async_reset", tx_valid, rx_ready, Dbus);
    @(posedge CLK);
    #1;
    chk("arst_edge.rx_ready", 16'(rx_ready), 16'd1);
    @(negedge CLK);
    RST = 1'b0;
    {Ain, Din, drv, Dout, read, write, tx_ready, rx_valid} = '0;

    add("r_ain_ff3",  F_AIN | F_DOUT | F_CHK, 12'hFF3, 0, 0, 0, 0, 1, 16'h0000);
    add("r_ain_ff2",  F_AIN, 12'hFF2, 0, 0, 0, 0, 1, 0);
    add("r_rd_cnt",   F_RD | F_DOUT | F_CHK, 0, 0, 0, 0, 0, 1, 16'h0000);
    add("r_ain_ff0",  F_AIN, 12'hFF0, 0, 0, 0, 0, 1, 0);
    add("r_rd_empty", F_RD | F_DOUT | F_CHK, 0, 0, 0, 0, 0, 1, 16'h0000);
    run_vecs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
